// File: rtl/with_mux.sv
// with_mux: registered 2-bit x 2-bit unsigned multiplier realised as a 2:1 mux tree.
//
// Operand A is {a,b} and operand B is {c,d}, with a and c as the MSBs.
// Each product bit comes from its own 8:1 mux. The select is {a,b,c} and the
// data inputs are drawn only from 0, 1, d and ~d. The four mux outputs are
// registered once, so there is one cycle of latency.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset; forces the product register to 0000
//   a, b  operand A (a = MSB)
//   c, d  operand B (c = MSB)
//   f0-f3 registered product bits (f3 = MSB)
module with_mux (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic f0,
  output logic f1,
  output logic f2,
  output logic f3
);

  // Reusable 2:1 cell. Every larger mux is built only from this cell.
  function automatic logic mux2(input logic sel, input logic in0, input logic in1);
    return sel ? in1 : in0;
  endfunction

  // 4:1 mux built from three 2:1 cells. Bit k of 'in' is selected when sel == k.
  function automatic logic mux4(input logic [1:0] sel, input logic [3:0] in);
    return mux2(sel[1], mux2(sel[0], in[0], in[1]), mux2(sel[0], in[2], in[3]));
  endfunction

  // 8:1 mux built from two 4:1 muxes plus one 2:1 cell.
  function automatic logic mux8(input logic [2:0] sel, input logic [7:0] in);
    return mux2(sel[2], mux4(sel[1:0], in[3:0]), mux4(sel[1:0], in[7:4]));
  endfunction

  logic [2:0] sel;
  logic       nd;
  logic [7:0] data_f0, data_f1, data_f2, data_f3;
  logic [3:0] prod_d, prod_q;

  assign sel = {a, b, c};
  assign nd  = ~d;

  // Data vectors are written with the input for sel = 7 on the left and sel = 0 on the right.
  assign data_f0 = {d,    d,    1'b0, 1'b0, d,    d,    1'b0, 1'b0};
  assign data_f1 = {nd,   d,    d,    d,    1'b1, 1'b0, 1'b0, 1'b0};
  assign data_f2 = {nd,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  assign data_f3 = {d,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  always_comb begin
    prod_d    = '0;
    prod_d[0] = mux8(sel, data_f0);
    prod_d[1] = mux8(sel, data_f1);
    prod_d[2] = mux8(sel, data_f2);
    prod_d[3] = mux8(sel, data_f3);
  end

  // Reset takes priority over capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
    end else begin
      prod_q <= prod_d;
    end
  end

  assign f0 = prod_q[0];
  assign f1 = prod_q[1];
  assign f2 = prod_q[2];
  assign f3 = prod_q[3];

endmodule

// File: tb/tb_with_mux.sv
module tb_with_mux;

  logic clk;
  logic rst;
  logic a, b, c, d;
  logic f0, f1, f2, f3;
  logic [3:0] f;

  int checks;
  int errors;

  with_mux dut (
    .clk(clk),
    .rst(rst),
    .a  (a),
    .b  (b),
    .c  (c),
    .d  (d),
    .f0 (f0),
    .f1 (f1),
    .f2 (f2),
    .f3 (f3)
  );

  assign f = {f3, f2, f1, f0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: reset gives zero, otherwise the plain unsigned product of the two operands.
  function automatic logic [3:0] model(input logic r, input logic [3:0] v);
    int p;
    p = int'(v[3:2]) * int'(v[1:0]);
    return r ? 4'd0 : p[3:0];
  endfunction

  // Drive one operand pair (and reset) for one cycle, then check just after the edge.
  task automatic step(input logic r, input logic [3:0] v, input logic [3:0] exp,
                      input string tag);
    rst = r;
    {a, b, c, d} = v;
    @(posedge clk);
    #1;
    checks++;
    assert (f === exp) else begin
      errors++;
      $error("FAIL %s: in=%b rst=%b observed %b expected %b", tag, v, r, f, exp);
    end
  endtask

  initial begin
    logic [3:0] v;
    logic       r;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    {a, b, c, d} = 4'b1111;
    #2;

    // Reset held two cycles with all inputs high, then released.
    step(1'b1, 4'b1111, 4'b0000, "reset_cycle1");
    step(1'b1, 4'b1111, 4'b0000, "reset_cycle2");
    step(1'b0, 4'b1111, 4'b1001, "reset_release");

    // Exhaustive sweep, one value per cycle.
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      step(1'b0, v, model(1'b0, v), $sformatf("exhaustive_%0d", i));
    end

    // Zero operands.
    step(1'b0, 4'b0011, 4'b0000, "zero_a");
    step(1'b0, 4'b1100, 4'b0000, "zero_b");

    // Inverted-d paths on f1 and f2.
    step(1'b0, 4'b1110, 4'b0110, "inv_d_6");
    step(1'b0, 4'b1111, 4'b1001, "inv_d_9");

    // Back-to-back changes.
    step(1'b0, 4'b0101, 4'b0001, "b2b_1");
    step(1'b0, 4'b1010, 4'b0100, "b2b_4");
    step(1'b0, 4'b1111, 4'b1001, "b2b_9");

    // Mid-stream reset.
    step(1'b0, 4'b1011, 4'b0110, "mid_hold");
    step(1'b1, 4'b1011, 4'b0000, "mid_reset");
    step(1'b0, 4'b1011, 4'b0110, "mid_release");

    // Randomized operands with occasional reset.
    for (int i = 0; i < 64; i++) begin
      v = 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 7) == 0);
      step(r, v, model(r, v), $sformatf("random_%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
